// File: rtl/riscv_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds the S_CSUM state.
package riscv_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

    // Header word count is legal when 1 <= n <= 2**addr_w.
    function automatic logic len_ok(input logic [31:0] n, input int unsigned addr_w);
        logic [32:0] lim;
        lim = 33'd1 << addr_w;
        return (n != 32'd0) && ({1'b0, n} <= lim);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// word_o already contains the byte being accepted this cycle, so the
// caller can capture a complete word on the same edge as the 4th byte.
module word_packer
    import riscv_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [31:0] asm_q, asm_d;
    logic [1:0]  idx_q;

    // Merge the incoming byte into its lane of the assembly register.
    always_comb begin
        asm_d = asm_q;
        asm_d[{idx_q, 3'b000} +: 8] = byte_i;
        word_o       = asm_d;
        word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
    end

    // Assembly register and byte index; clear wins over a byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (clear_i) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (byte_valid_i) begin
            asm_q <= asm_d;
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into
// instruction memory word by word and holds the core in reset until the
// image is complete. Optional macro IMEM_LOADER_CHECKSUM_EN appends an XOR
// checksum byte after the data that must match before the core is released.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is registered from the next state, so it never depends on
// rx_valid combinationally; rx_valid while rx_ready=0 leaves the byte
// pending upstream. A load_req on the same edge drops the transfer.
module imem_boot_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [2:0]        dbg_state
);

    loader_state_t     state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [LEN_W:0]    word_cnt_q, word_cnt_d;
    logic [LEN_W:0]    word_cnt_inc;
    logic [LEN_W-1:0]  hdr_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept;
    logic        pk_clear;
    logic        pk_byte;
    logic [31:0] pk_word;
    logic        pk_word_valid;
    logic        data_wr;
    logic        last_word;

    assign accept       = rx_valid && rx_ready_q;
    assign hdr_len      = LEN_W'({rx_data, len_lo_q});
    assign word_cnt_inc = word_cnt_q + {{LEN_W{1'b0}}, 1'b1};

    word_packer u_packer (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_byte),
        .byte_i       (rx_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // Data-path strobes feeding the packer and the memory write port.
    always_comb begin
        pk_clear  = load_req || ((state_q == S_LEN1) && accept);
        pk_byte   = !load_req && (state_q == S_DATA) && accept;
        data_wr   = pk_byte && pk_word_valid;
        last_word = data_wr && (word_cnt_inc == {1'b0, n_q});
    end

    // Next-state and next-register logic of the load FSM.
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (load_req) begin
            state_d    = S_LEN0;
            len_lo_d   = '0;
            n_d        = '0;
            word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else begin
            case (state_q)
                S_LEN0: begin
                    if (accept) begin
                        len_lo_d = rx_data;
                        state_d  = S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        if (!len_ok(32'(hdr_len), ADDR_W)) begin
                            state_d = S_ERR;
                        end else begin
                            n_d        = hdr_len;
                            word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_d     = '0;
`endif
                            state_d    = S_DATA;
                        end
                    end
                end
                S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        csum_d = csum_q ^ rx_data;
                    end
`endif
                    if (data_wr) begin
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = pk_word;
                        word_cnt_d   = word_cnt_inc;
                    end
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_RUN;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
                    end
                end
`endif
                S_RUN:   state_d = S_RUN;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_LEN0;
            endcase
        end
    end

    // Registered outputs derived from the next state or current state.
    always_comb begin
        rx_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        rx_ready_d = rx_ready_d || (state_d == S_CSUM);
`endif
        imem_we_d   = data_wr;
        cpu_rst_n_d = (state_q == S_RUN) && !load_req;
        load_done_d = (state_q == S_RUN) && !load_req;
        load_err_d  = (state_d == S_ERR) && !load_req;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LEN0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            len_lo_q     <= '0;
            n_q          <= '0;
            word_cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            len_lo_q     <= len_lo_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;

    localparam logic [2:0] ST_LEN0 = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // Clock and reset.
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic load_req = 1'b0;

    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_err   (load_err),
        .dbg_state  (dbg_state)
    );

    // Scoreboard state.
    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];
    logic [39:0] wr_q[$];
    logic [31:0] words[$];
    logic [7:0]  last_xor;

    // Capture every memory write strobe just after the edge that sets it.
    always @(posedge clk) begin
        #1;
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present one byte after 'gap' idle cycles, hold until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk("byte_timeout", 64'(rx_ready), 64'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Header plus all entries of 'words'; fills exp_q and last_xor.
    task automatic send_frame(input logic [15:0] n_hdr, input int gap_max);
        logic [7:0] b;
        exp_q.delete();
        wr_q.delete();
        last_xor = 8'h00;
        send_byte(n_hdr[7:0], 0);
        send_byte(n_hdr[15:8], 0);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                last_xor = last_xor ^ b;
                send_byte(b, $urandom_range(0, gap_max));
            end
            exp_q.push_back({8'(i), words[i]});
        end
    endtask

    task automatic send_csum_ok();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(last_xor, 0);
`endif
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({tag, "_entry"}, 64'(wr_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready",  64'(rx_ready),   64'd0);
        chk("rst_imem_we",   64'(imem_we),    64'd0);
        chk("rst_imem_addr", 64'(imem_addr),  64'd0);
        chk("rst_wdata",     64'(imem_wdata), 64'd0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n),  64'd0);
        chk("rst_load_done", 64'(load_done),  64'd0);
        chk("rst_load_err",  64'(load_err),   64'd0);
        chk("rst_state",     64'(dbg_state),  64'(ST_LEN0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 64'(rx_ready), 64'd1);

        // Two-word frame, back to back.
        words = '{32'h00A00513, 32'h00100593};
        send_frame(16'd2, 0);
        send_csum_ok();
`ifndef IMEM_LOADER_CHECKSUM_EN
        chk("f2_we_last", 64'(imem_we), 64'd1);
`endif
        chk("f2_rst_before", 64'(cpu_rst_n), 64'd0);
        @(negedge clk);
        chk("f2_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        chk("f2_load_done", 64'(load_done), 64'd1);
        chk("f2_we_low",    64'(imem_we),   64'd0);
        chk("f2_rx_ready",  64'(rx_ready),  64'd0);
        check_writes("f2");

        // Bytes offered while running are ignored.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        chk("run_no_wr",  64'(wr_q.size()), 64'd2);
        chk("run_state",  64'(dbg_state),   64'(ST_RUN));

        // Zero-length header.
        pulse_load();
        chk("lr_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("lr_load_done", 64'(load_done), 64'd0);
        chk("lr_state",     64'(dbg_state), 64'(ST_LEN0));
        words.delete();
        send_frame(16'h0000, 0);
        chk("n0_load_err",  64'(load_err),  64'd1);
        chk("n0_rx_ready",  64'(rx_ready),  64'd0);
        chk("n0_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("n0_state",     64'(dbg_state), 64'(ST_ERR));
        repeat (3) @(negedge clk);
        chk("n0_err_hold",  64'(load_err),  64'd1);
        chk("n0_rst_hold",  64'(cpu_rst_n), 64'd0);
        check_writes("n0");

        // N = 257 is one past the memory depth.
        pulse_load();
        chk("lr_err_clr", 64'(load_err), 64'd0);
        send_frame(16'h0101, 0);
        chk("n257_err",   64'(load_err),  64'd1);
        chk("n257_state", 64'(dbg_state), 64'(ST_ERR));
        check_writes("n257");

        // N = 256 fills the memory exactly.
        pulse_load();
        for (int i = 0; i < 256; i++)
            words.push_back({8'(i), ~8'(i), 8'hA5, 8'(i * 3)});
        send_frame(16'h0100, 0);
        send_csum_ok();
        @(negedge clk);
        chk("n256_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        chk("n256_load_done", 64'(load_done), 64'd1);
        check_writes("n256");
        if (wr_q.size() != 0)
            chk("n256_last_addr", 64'(wr_q[wr_q.size()-1][39:32]), 64'h0FF);

        // Three-word frame with random idle gaps on rx_valid.
        pulse_load();
        words = '{32'h00500093, 32'h00108113, 32'hFE209EE3};
        send_frame(16'd3, 3);
        send_csum_ok();
        @(negedge clk);
        chk("gap_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        check_writes("gap");

        // Abort after 5 data bytes of a 2-word frame.
        pulse_load();
        wr_q.delete();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 1);
        send_byte(8'hA0, 0);
        send_byte(8'h00, 2);
        send_byte(8'h93, 0);
        pulse_load();
        chk("ab_count", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() != 0)
            chk("ab_word0", 64'(wr_q[0]), 64'({8'h00, 32'h00A00513}));
        chk("ab_state",     64'(dbg_state), 64'(ST_LEN0));
        chk("ab_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        words = '{32'hCAFEF00D};
        send_frame(16'd1, 1);
        send_csum_ok();
        @(negedge clk);
        chk("ab_new_run", 64'(cpu_rst_n), 64'd1);
        check_writes("ab_new");

        // load_req while running drops reset to the core at the next edge.
        load_req = 1'b1;
        @(posedge clk);
        #1;
        chk("lr_run_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("lr_run_done",  64'(load_done), 64'd0);
        @(negedge clk);
        load_req = 1'b0;

        // load_req beats a simultaneous byte accept.
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        chk("lr_prio_state", 64'(dbg_state), 64'(ST_LEN0));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accepted.
        pulse_load();
        words = '{32'h44332211};
        send_frame(16'd1, 0);
        send_byte(8'h44, 0);
        @(negedge clk);
        chk("cs_ok_run", 64'(cpu_rst_n), 64'd1);
        check_writes("cs_ok");
        // Checksum rejected: word stays written, core stays in reset.
        pulse_load();
        send_frame(16'd1, 0);
        send_byte(8'h00, 0);
        chk("cs_bad_err", 64'(load_err), 64'd1);
        @(negedge clk);
        chk("cs_bad_rst",   64'(cpu_rst_n), 64'd0);
        chk("cs_bad_state", 64'(dbg_state), 64'(ST_ERR));
        check_writes("cs_bad");
`endif

        // Asynchronous reset in the middle of a frame.
        pulse_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state",    64'(dbg_state), 64'(ST_LEN0));
        chk("ar_rx_ready", 64'(rx_ready),  64'd0);
        chk("ar_cpu_rst",  64'(cpu_rst_n), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready_back", 64'(rx_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
